// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//
// One-hot step generator for a multi-cycle processor datapath
// (fetch/decode/execute/memory/writeback, or as many steps as configured).
// The sequence advances on an internal clock-enable prescaler, so the whole
// design runs on a single clock with no derived clocks. The control unit
// uses the step outputs to gate its per-phase register enables.
//
// Parameters:
//   NUM_STEPS  number of steps per instruction (>= 2); width of step
//   DIV        clk cycles per step advance (>= 1)
//   IDX_W      width of the binary step index (derived, not overridable)
//
// Ports:
//   clk         system clock, all state on its rising edge
//   reset       synchronous, active-low reset (0 = reset)
//   stall       level; the step holds at every tick while high
//   last_step   level; the current step ends this instruction early
//   halt        level; freeze at step 0 once the current instruction ends
//   step        registered one-hot step, bit 0 = first step
//   step_idx    registered binary index of the active step
//   tick        one-cycle pulse in the cycle after the step advanced
//   instr_done  one-cycle pulse in the first cycle back at step 0 after a wrap
//   halted      level; the sequencer is frozen at step 0
// ---------------------------------------------------------------------------
module step_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int DIV       = 2,
  localparam int IDX_W    = $clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 last_step,
  input  logic                 halt,
  output logic [NUM_STEPS-1:0] step,
  output logic [IDX_W-1:0]     step_idx,
  output logic                 tick,
  output logic                 instr_done,
  output logic                 halted
);

  // Reject configurations that cannot form a sequence or a prescaler.
  if (NUM_STEPS < 2) begin : g_bad_steps
    $error("step_sequencer: NUM_STEPS must be >= 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("step_sequencer: DIV must be >= 1");
  end

  // A one-bit counter is kept even for DIV = 1; it then simply stays at 0.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [NUM_STEPS-1:0] STEP_FIRST = {{(NUM_STEPS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]     r_div_cnt;
  logic [IDX_W-1:0]     r_step_idx;
  logic [NUM_STEPS-1:0] r_step;
  logic                 r_tick;
  logic                 r_instr_done;
  logic                 r_halted;

  logic                 w_tick_en;
  logic                 w_adv;
  logic                 w_wrap;
  logic                 w_idx_bad;
  logic [IDX_W-1:0]     w_next_idx;

  // Inputs only matter on the prescaler's terminal count.
  assign w_tick_en  = (r_div_cnt == CNT_LAST);
  assign w_adv      = w_tick_en & ~stall & ~r_halted;
  assign w_wrap     = (r_step_idx == IDX_LAST) | last_step;
  assign w_next_idx = r_step_idx + IDX_W'(1);

  // The extra leading bit keeps this a real comparison even when NUM_STEPS
  // is a power of two and an out-of-range index cannot be represented.
  assign w_idx_bad  = ({1'b0, r_step_idx} >= (IDX_W + 1)'(NUM_STEPS));

  // Free-running prescaler; stall and halt never pause it, so advances
  // always land on multiples of DIV after reset release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (w_tick_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  // Step sequencing, halt handling and the pulse outputs. The pulses
  // default low every cycle so they last exactly one clock. An index that
  // somehow left the legal range is pulled back to step 0 before anything
  // else is considered. While halted, a tick with halt low only clears the
  // halt; the step stays at 0 and advancing resumes on the following tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_step_idx   <= '0;
      r_step       <= STEP_FIRST;
      r_tick       <= 1'b0;
      r_instr_done <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_tick       <= 1'b0;
      r_instr_done <= 1'b0;
      if (w_idx_bad) begin
        r_step_idx <= '0;
        r_step     <= STEP_FIRST;
      end else if (w_tick_en && r_halted) begin
        if (!halt) begin
          r_halted <= 1'b0;
        end
      end else if (w_adv) begin
        r_tick <= 1'b1;
        if (w_wrap) begin
          r_step_idx   <= '0;
          r_step       <= STEP_FIRST;
          r_instr_done <= 1'b1;
          r_halted     <= halt;
        end else begin
          r_step_idx <= w_next_idx;
          r_step     <= STEP_FIRST << w_next_idx;
        end
      end
    end
  end

  assign step       = r_step;
  assign step_idx   = r_step_idx;
  assign tick       = r_tick;
  assign instr_done = r_instr_done;
  assign halted     = r_halted;

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
//
// Drives two sequencers from the same inputs: the default configuration
// (NUM_STEPS=5, DIV=2) and a wide, undivided one (NUM_STEPS=8, DIV=1).
// A behavioural model tracks the expected step number, halt state and
// pulses from the cycle count since reset; every cycle both DUTs are
// compared against it, and a few hand-computed values pin the model.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       last_step;
  logic       halt;

  logic [4:0] stepA;
  logic [2:0] idxA;
  logic       tickA, doneA, haltedA;
  logic [7:0] stepB;
  logic [2:0] idxB;
  logic       tickB, doneB, haltedB;

  int passCount;
  int totalCount;

  // Model state per instance: step number, cycles since reset release,
  // halted flag and the two pulses.
  int mIdxA, mCycA, mIdxB, mCycB;
  bit mHaltA, mTickA, mDoneA, mHaltB, mTickB, mDoneB;

  step_sequencer #(.NUM_STEPS(5), .DIV(2)) dutA (
    .clk(clk), .reset(reset), .stall(stall), .last_step(last_step), .halt(halt),
    .step(stepA), .step_idx(idxA), .tick(tickA), .instr_done(doneA), .halted(haltedA)
  );

  step_sequencer #(.NUM_STEPS(8), .DIV(1)) dutB (
    .clk(clk), .reset(reset), .stall(stall), .last_step(last_step), .halt(halt),
    .step(stepB), .step_idx(idxB), .tick(tickB), .instr_done(doneB), .halted(haltedB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge of the behavioural model for an instance with n steps
  // and a prescaler of dv. A tick happens every dv-th cycle after reset.
  task automatic modelEdge(input int n, input int dv, input bit rstN,
                           input bit st, input bit ls, input bit hl,
                           inout int idx, inout int cyc, inout bit hlt,
                           inout bit tk, inout bit dn);
    bit tickEn;
    if (!rstN) begin
      idx = 0; cyc = 0; hlt = 0; tk = 0; dn = 0;
    end else begin
      tickEn = ((cyc % dv) == dv - 1);
      cyc++;
      tk = 0;
      dn = 0;
      if (tickEn) begin
        if (hlt) begin
          if (!hl) hlt = 0;
        end else if (!st) begin
          tk = 1;
          if (idx == n - 1 || ls) begin
            idx = 0;
            dn = 1;
            hlt = hl;
          end else begin
            idx = idx + 1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("A.step",       int'(stepA),   1 << mIdxA);
    checkOutput("A.step_idx",   int'(idxA),    mIdxA);
    checkOutput("A.tick",       int'(tickA),   int'(mTickA));
    checkOutput("A.instr_done", int'(doneA),   int'(mDoneA));
    checkOutput("A.halted",     int'(haltedA), int'(mHaltA));
    checkOutput("B.step",       int'(stepB),   1 << mIdxB);
    checkOutput("B.step_idx",   int'(idxB),    mIdxB);
    checkOutput("B.tick",       int'(tickB),   int'(mTickB));
    checkOutput("B.instr_done", int'(doneB),   int'(mDoneB));
    checkOutput("B.halted",     int'(haltedB), int'(mHaltB));
  endtask

  // One clock: inputs are already stable, the model follows the rising
  // edge and the DUTs are compared on the falling edge.
  task automatic runCycle();
    @(posedge clk);
    modelEdge(5, 2, reset, stall, last_step, halt, mIdxA, mCycA, mHaltA, mTickA, mDoneA);
    modelEdge(8, 1, reset, stall, last_step, halt, mIdxB, mCycB, mHaltB, mTickB, mDoneB);
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyStimulus(input bit rstN, input bit st, input bit ls,
                               input bit hl, input int cycles);
    reset     = rstN;
    stall     = st;
    last_step = ls;
    halt      = hl;
    for (int i = 0; i < cycles; i++) runCycle();
  endtask

  logic [4:0] expStep [10];
  logic       expTick [10];
  logic       expDone [10];
  int         stallHold;
  bit         haltLevel;

  initial begin
    passCount  = 0;
    totalCount = 0;
    reset = 1'b0; stall = 1'b0; last_step = 1'b0; halt = 1'b0;
    mIdxA = 0; mCycA = 0; mHaltA = 0; mTickA = 0; mDoneA = 0;
    mIdxB = 0; mCycB = 0; mHaltB = 0; mTickB = 0; mDoneB = 0;
    @(negedge clk);

    // Reset held for three clocks.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("reset.step",   int'(stepA),   1);
    checkOutput("reset.idx",    int'(idxA),    0);
    checkOutput("reset.tick",   int'(tickA),   0);
    checkOutput("reset.done",   int'(doneA),   0);
    checkOutput("reset.halted", int'(haltedA), 0);

    // Basic sequence after release: a change every second clock,
    // wrapping back to step 0 on the tenth edge.
    expStep = '{5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100,
                5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b00001};
    expTick = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    expDone = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      runCycle();
      checkOutput($sformatf("basic.step[%0d]", i), int'(stepA), int'(expStep[i]));
      checkOutput($sformatf("basic.tick[%0d]", i), int'(tickA), int'(expTick[i]));
      checkOutput($sformatf("basic.done[%0d]", i), int'(doneA), int'(expDone[i]));
    end

    // Advance to step 2 (four more clocks), then stall for six clocks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
    checkOutput("prestall.step", int'(stepA), 5'b00100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6);
    checkOutput("stall.step", int'(stepA), 5'b00100);
    checkOutput("stall.idx",  int'(idxA),  2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("unstall.step", int'(stepA), 5'b01000);

    // Early termination from step 3 with last_step.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2);
    checkOutput("early.step", int'(stepA), 5'b00001);
    checkOutput("early.done", int'(doneA), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("early.donePulse", int'(doneA), 0);

    // Halt held long enough for the instruction to finish, then released.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 30);
    checkOutput("halt.halted", int'(haltedA), 1);
    checkOutput("halt.step",   int'(stepA),   5'b00001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("release.halted", int'(haltedA), 0);
    checkOutput("release.step",   int'(stepA),   5'b00001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("release.advance", int'(stepA), 5'b00010);

    // Reset for one clock in the middle of an instruction.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("midreset.step", int'(stepA), 5'b00001);
    checkOutput("midreset.tick", int'(tickA), 0);

    // Randomized traffic: stall as short bursts, halt as a slowly
    // changing level, occasional single-cycle resets.
    stallHold = 0;
    haltLevel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (stallHold > 0) stallHold--;
      else if ($urandom_range(0, 9) == 0) stallHold = $urandom_range(1, 8);
      if ($urandom_range(0, 23) == 0) haltLevel = ~haltLevel;
      applyStimulus(($urandom_range(0, 199) != 0), (stallHold > 0),
                    ($urandom_range(0, 6) == 0), haltLevel, 1);
    end

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Parametrised one-hot step generator that sequences the multi-cycle datapath (fetch/decode/execute/memory/writeback, or more) of the processor.
- Advances on an internal clock-enable prescaler rather than a derived clock. Adds stall, early instruction termination and halt.
- Sits between the top-level clock/reset and the control unit; its step outputs gate per-phase register enables.

Parameters:
- NUM_STEPS, 5, number of steps per instruction; width of the one-hot output; legal range >= 2.
- DIV, 2, clk cycles per step advance (prescaler ratio); legal range >= 1.
- IDX_W, $clog2(NUM_STEPS), width of the binary step index (derived; do not override).

Ports:
- clk  in  1  system clock; the only clock; all state on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset); sampled on posedge clk.
- stall  in  1  level; while 1, step holds at every tick.
- last_step  in  1  level; current step is the final one of this instruction, so wrap to step 0 at the next advance.
- halt  in  1  level; request to freeze at step 0 after the current instruction completes.
- step  out  NUM_STEPS  one-hot step; bit 0 = first step; registered.
- step_idx  out  IDX_W  binary index of the active step; registered; always consistent with step.
- tick  out  1  one-cycle pulse, high in the cycle immediately after step changed.
- instr_done  out  1  one-cycle pulse, high in the first cycle step shows bit 0 after a wrap.
- halted  out  1  level; sequencer frozen at step 0.

Behaviour:
- Reset (reset == 0 at posedge clk):
  - step = 1 (bit 0), step_idx = 0, prescaler count = 0.
  - tick = 0, instr_done = 0, halted = 0.
  - Reset has priority over all other inputs and aborts any operation in progress.
- Prescaler:
  - div_cnt counts 0..DIV-1 and then wraps; it free-runs regardless of stall or halted.
  - tick_en = (div_cnt == DIV-1). With DIV = 1, tick_en is 1 every cycle.
  - First possible advance is DIV cycles after reset release.
- Advance condition: adv = tick_en & ~stall & ~halted. On adv:
  - If step_idx == NUM_STEPS-1 or last_step == 1: step_idx <- 0; instr_done = 1 next cycle. If halt == 1 in that same cycle, halted <- 1.
  - Otherwise step_idx <- step_idx + 1.
  - tick = 1 in the cycle after any adv, including a wrap.
- Step encoding: step is registered as 1 << next step_idx, updated on the same edge as step_idx. There is no combinational path from inputs to outputs.
- Halt release: when halted == 1 and tick_en & ~halt, halted <- 0. Step stays at 0 on that tick, with no tick or instr_done pulse. Advance resumes on the following tick_en.
- Priorities:
  - stall overrides last_step and halt in the same cycle; no state change occurs.
  - last_step at step 0 gives a single-step instruction: wrap 0 -> 0 with tick and instr_done.
  - halt asserted mid-instruction is ignored until the wrap. If halt is deasserted before the wrap, no halt occurs.
  - stall while halted has no additional effect.
- Inputs are sampled only at tick_en; values between ticks are don't-care.
- Robustness: any step_idx >= NUM_STEPS (unreachable) forces step_idx <- 0 and step <- 1 on the next edge.
- Elaboration error if NUM_STEPS < 2 or DIV < 1.
- Timing: step changes DIV clk cycles apart in steady state. Stall or halt extends this in multiples of DIV.

Test Plan:
- Basic sequence (NUM_STEPS=5, DIV=2): hold reset=0 for 3 clk -> step=00001, step_idx=0, tick=instr_done=halted=0. Release -> step 00001->00010->00100->01000->10000->00001, each change 2 clk apart, tick pulses each change, instr_done pulses once on return to 00001.
- Stall: raise stall at step 00100 for 6 clk -> step/step_idx hold at 00100/2, tick=0. Drop stall -> 01000 at the next tick_en.
- Early termination: last_step=1 while step=00100 -> next step=00001 with instr_done=1 for one cycle. Next instruction restarts the full 5-step sequence.
- Halt: assert halt at step 00010 and keep it high -> sequence continues to 10000, wraps to 00001, instr_done pulses, halted=1, step frozen for 10 clk. Deassert halt -> halted=0 at the next tick_en, step still 00001, then 00010 one tick later.
- Reset mid-operation: drive reset=0 for 1 clk while step=01000 and div_cnt=1 -> next edge step=00001, step_idx=0, halted=0, tick=0. Prescaler restarts from 0.
- Generics (NUM_STEPS=8, DIV=1): step advances every clk through 8 one-hot states, step_idx 0..7. Wrap after bit 7 with instr_done. stall and last_step behave identically.
